// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// The result vector is ordered {eq, lt, gt}.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] CMP_NONE = 3'b000;
  localparam logic [2:0] CMP_EQ   = 3'b100;
  localparam logic [2:0] CMP_LT   = 3'b010;
  localparam logic [2:0] CMP_GT   = 3'b001;

  // Width of a counter that must hold the values 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mag_bit_cmp.sv
// Combinational 1-bit unsigned compare cell.
module mag_bit_cmp (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic lt,
  output logic gt
);

  assign eq = ~(a ^ b);
  assign lt = ~a & b;
  assign gt = a & ~b;

endmodule

// File: rtl/serial_mag_cmp.sv
// Multi-cycle unsigned magnitude comparator: scans the operands MSB-first,
// one bit per cycle, and returns a one-hot {eq, lt, gt} over valid/ready.
module serial_mag_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a_in,
  input  logic [WIDTH-1:0]             b_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         eq,
  output logic                         lt,
  output logic                         gt,
  output logic [cnt_width(WIDTH)-1:0]  cycles
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic             dec_lt, dec_gt;
  logic [2:0]       res_q;

  logic bit_eq, bit_lt, bit_gt;
  logic decided, hit_lt, hit_gt, last_bit, finish;
  logic accept, release_res;

  mag_bit_cmp u_cell (
    .a  (a_sr[WIDTH-1]),
    .b  (b_sr[WIDTH-1]),
    .eq (bit_eq),
    .lt (bit_lt),
    .gt (bit_gt)
  );

  // The first differing bit wins; later bits cannot override a decision.
  always_comb begin
    decided  = dec_lt | dec_gt;
    hit_lt   = dec_lt | (~decided & bit_lt);
    hit_gt   = dec_gt | (~decided & bit_gt);
    last_bit = (bit_cnt == '0);
    finish   = last_bit | (EARLY_EXIT & ~bit_eq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    // this block can leave a signal unassigned and infer a latch.
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          release_res = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the operand shift registers are reset along with the control state,
  // so an aborted comparison leaves no stale operand bits behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      bit_cnt <= '0;
      cycles  <= '0;
      dec_lt  <= 1'b0;
      dec_gt  <= 1'b0;
      res_q   <= CMP_NONE;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values of its neighbours, independent of statement order.
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr    <= a_in;
            b_sr    <= b_in;
            bit_cnt <= CNT_W'(WIDTH - 1);
            cycles  <= '0;
            dec_lt  <= 1'b0;
            dec_gt  <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr   <= {a_sr[WIDTH-2:0], 1'b0};
          b_sr   <= {b_sr[WIDTH-2:0], 1'b0};
          cycles <= cycles + CNT_W'(1);
          dec_lt <= hit_lt;
          dec_gt <= hit_gt;
          if (!last_bit) bit_cnt <= bit_cnt - CNT_W'(1);
          if (finish) begin
            if (hit_lt)      res_q <= CMP_LT;
            else if (hit_gt) res_q <= CMP_GT;
            else             res_q <= CMP_EQ;
          end
        end
        DONE: begin
          if (release_res) res_q <= CMP_NONE;
        end
        default: ;
      endcase
    end
  end

  assign {eq, lt, gt} = res_q;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Self-checking bench for serial_mag_cmp: three builds (8-bit early exit,
// 8-bit constant latency, 13-bit early exit) driven with directed vectors.
module tb_serial_mag_cmp;
  import cmp_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [N];
  logic        in_ready  [N];
  logic [15:0] a_in      [N];
  logic [15:0] b_in      [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic        eq        [N];
  logic        lt        [N];
  logic        gt        [N];
  logic [3:0]  cycles    [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_mag_cmp #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_w8_early (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a_in(a_in[0][7:0]), .b_in(b_in[0][7:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .eq(eq[0]), .lt(lt[0]), .gt(gt[0]), .cycles(cycles[0])
  );

  serial_mag_cmp #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_w8_const (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a_in(a_in[1][7:0]), .b_in(b_in[1][7:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .eq(eq[1]), .lt(lt[1]), .gt(gt[1]), .cycles(cycles[1])
  );

  serial_mag_cmp #(.WIDTH(13), .EARLY_EXIT(1'b1)) u_w13_early (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a_in(a_in[2][12:0]), .b_in(b_in[2][12:0]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .eq(eq[2]), .lt(lt[2]), .gt(gt[2]), .cycles(cycles[2])
  );

  typedef struct {
    int          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] res_of(input int s);
    return {eq[s], lt[s], gt[s]};
  endfunction

  function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b,
                                 input int w, input bit ee);
    if (!ee) return w;
    for (int i = w - 1; i >= 0; i--)
      if (a[i] != b[i]) return w - i;
    return w;
  endfunction

  function automatic logic [2:0] ref_res(input logic [15:0] a, input logic [15:0] b);
    if (a == b) return CMP_EQ;
    if (a < b)  return CMP_LT;
    return CMP_GT;
  endfunction

  // One full transaction; out_ready is held low for 'stall' cycles of DONE.
  task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                        input int stall, input logic [2:0] exp_res, input int exp_lat,
                        input string tag);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready[sel] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, ".in_ready"}, 32'(in_ready[sel]), 32'd1);
    in_valid[sel] = 1'b1;
    a_in[sel]     = av;
    b_in[sel]     = bv;
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    a_in[sel]     = ~av;
    b_in[sel]     = av;
    lat = 0;
    while (!out_valid[sel] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".res"}, 32'(res_of(sel)), 32'(exp_res));
    check({tag, ".cycles"}, 32'(cycles[sel]), 32'(exp_lat));
    check({tag, ".onehot"}, 32'($countones(res_of(sel))), 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold"}, {27'd0, out_valid[sel], res_of(sel)}, {27'd0, 1'b1, exp_res});
    end
    out_ready[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready[sel] = 1'b0;
    check({tag, ".release"}, {28'd0, out_valid[sel], res_of(sel)}, 32'd0);
    check({tag, ".cycles_kept"}, 32'(cycles[sel]), 32'(exp_lat));
  endtask

  initial begin
    int          lat;
    int          seen;
    int          w;
    int          stall;
    bit          ee;
    logic [15:0] mask, av, bv, one;

    one = 16'd1;
    for (int s = 0; s < N; s++) begin
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b0;
      a_in[s]      = '0;
      b_in[s]      = '0;
    end

    // Directed vectors: {dut, a, b, expected result, expected latency}.
    vecs.push_back('{0, 16'h005A, 16'h005A, CMP_EQ, 8});
    vecs.push_back('{0, 16'h0080, 16'h007F, CMP_GT, 1});
    vecs.push_back('{0, 16'h0012, 16'h0013, CMP_LT, 8});
    vecs.push_back('{0, 16'h0030, 16'h0020, CMP_GT, 4});
    vecs.push_back('{0, 16'h00FF, 16'h0000, CMP_GT, 1});
    vecs.push_back('{0, 16'h0000, 16'h00FF, CMP_LT, 1});
    vecs.push_back('{0, 16'h0000, 16'h0000, CMP_EQ, 8});
    vecs.push_back('{0, 16'h0001, 16'h0000, CMP_GT, 8});
    vecs.push_back('{0, 16'h007F, 16'h0080, CMP_LT, 1});
    vecs.push_back('{0, 16'h0008, 16'h0010, CMP_LT, 4});
    vecs.push_back('{1, 16'h0080, 16'h0000, CMP_GT, 8});
    vecs.push_back('{1, 16'h0081, 16'h0000, CMP_GT, 8});
    vecs.push_back('{1, 16'h0040, 16'h003F, CMP_GT, 8});
    vecs.push_back('{1, 16'h0000, 16'h0001, CMP_LT, 8});
    vecs.push_back('{1, 16'h0055, 16'h0055, CMP_EQ, 8});
    vecs.push_back('{2, 16'h1000, 16'h0FFF, CMP_GT, 1});
    vecs.push_back('{2, 16'h0001, 16'h0000, CMP_GT, 13});
    vecs.push_back('{2, 16'h1ABC, 16'h1ABC, CMP_EQ, 13});
    vecs.push_back('{2, 16'h0800, 16'h1000, CMP_LT, 1});

    rst_n = 1'b0;
    #1;
    for (int s = 0; s < N; s++) begin
      check("reset.in_ready", 32'(in_ready[s]), 32'd1);
      check("reset.outputs", {28'd0, out_valid[s], res_of(s)}, 32'd0);
      check("reset.cycles", 32'(cycles[s]), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, 0, vecs[i].res, vecs[i].lat, "vec");

    // Result held under back-pressure while in_valid stays high with new data.
    in_valid[0] = 1'b1;
    a_in[0]     = 16'h0030;
    b_in[0]     = 16'h0020;
    @(posedge clk); #1;
    a_in[0] = 16'h0000;
    b_in[0] = 16'h0000;
    lat = 0;
    while (!out_valid[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("stall.lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall.hold", {27'd0, out_valid[0], res_of(0)}, {27'd0, 1'b1, CMP_GT});
      check("stall.cycles", 32'(cycles[0]), 32'd4);
      check("stall.in_ready", 32'(in_ready[0]), 32'd0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("stall.release", {28'd0, out_valid[0], res_of(0)}, 32'd0);
    check("stall.idle_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("stall.reaccept", 32'(in_ready[0]), 32'd0);
    lat = 0;
    while (!out_valid[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("stall.next_lat", 32'(lat), 32'd8);
    check("stall.next_res", 32'(res_of(0)), 32'(CMP_EQ));
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    // Reset in the middle of a scan discards the comparison.
    in_valid[0] = 1'b1;
    a_in[0]     = 16'h0001;
    b_in[0]     = 16'h0001;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort.in_ready", 32'(in_ready[0]), 32'd1);
    check("abort.outputs", {28'd0, out_valid[0], res_of(0)}, 32'd0);
    check("abort.cycles", 32'(cycles[0]), 32'd0);
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (out_valid[0] || !in_ready[0]) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen++;
    end
    check("abort.no_result", 32'(seen), 32'd0);
    run_op(0, 16'h00FF, 16'h0000, 0, CMP_GT, 1, "abort.next");

    // Mixed stream against an unsigned reference compare.
    for (int s = 0; s < N; s++) begin
      w    = (s == 2) ? 13 : 8;
      ee   = (s != 1);
      mask = 16'((1 << w) - 1);
      for (int n = 0; n < 150; n++) begin
        av = 16'($urandom) & mask;
        case ($urandom_range(0, 2))
          0:       bv = av;
          1:       bv = av ^ (one << $urandom_range(0, w - 1));
          default: bv = 16'($urandom) & mask;
        endcase
        stall = $urandom_range(0, 3);
        run_op(s, av, bv, stall, ref_res(av, bv), ref_lat(av, bv, w, ee), "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
